// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 key matrix, debounces press and release, and
// emits a held one-hot digit plus single-cycle operator/control strobes.
module keypad_encoder #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 50000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic [9:0] number,
    output logic       start,
    output logic       add,
    output logic       sub,
    output logic       mult,
    output logic       div,
    output logic       enter,
    output logic       clr,
    output logic [3:0] key_code,
    output logic       busy
);
    localparam int MAXC = SCAN_DIV > DEBOUNCE ? SCAN_DIV : DEBOUNCE;
    localparam int W = $clog2(MAXC);
    localparam logic [W-1:0] SCAN_LAST = W'(SCAN_DIV - 1);
    localparam logic [W-1:0] DEB_LAST = W'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        S_SCAN, S_DEBOUNCE, S_EMIT, S_STROBE, S_HOLD, S_RELEASE
    } state_t;

    state_t state, state_n;
    logic [W-1:0] cnt, cnt_n;
    logic [1:0] r, r_n, c, c_n, low_col;
    logic key_high, is_digit, fire;
    logic [3:0] digit;

    assign key_high = col_n[c];
    assign low_col = !col_n[0] ? 2'd0 : !col_n[1] ? 2'd1 : !col_n[2] ? 2'd2 : 2'd3;
    assign is_digit = (r != 2'd3 && c != 2'd3) || (r == 2'd3 && c == 2'd1);
    assign digit = r == 2'd3 ? 4'd0 : 4'(r) * 4'd3 + 4'(c) + 4'd1;
    assign fire = state == S_STROBE;

    always_comb begin
        state_n = state;
        cnt_n = cnt + 1'b1;
        r_n = r;
        c_n = c;
        case (state)
            S_SCAN:
                if (cnt == SCAN_LAST) begin
                    cnt_n = '0;
                    if (col_n != 4'hf) begin
                        state_n = S_DEBOUNCE;
                        c_n = low_col;
                    end else begin
                        r_n = r + 2'd1;
                    end
                end
            S_DEBOUNCE:
                if (key_high) begin
                    state_n = S_SCAN;
                    cnt_n = '0;
                    r_n = r + 2'd1;
                end else if (cnt == DEB_LAST) begin
                    state_n = S_EMIT;
                    cnt_n = '0;
                end
            S_EMIT: begin
                state_n = S_STROBE;
                cnt_n = '0;
            end
            S_STROBE: begin
                state_n = S_HOLD;
                cnt_n = '0;
            end
            S_HOLD: begin
                cnt_n = '0;
                if (key_high) state_n = S_RELEASE;
            end
            S_RELEASE:
                if (!key_high) begin
                    state_n = S_HOLD;
                    cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = S_SCAN;
                    cnt_n = '0;
                    r_n = r + 2'd1;
                end
            default: begin
                state_n = S_SCAN;
                cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_SCAN;
            cnt <= '0;
            r <= 2'd0;
            c <= 2'd0;
            row_n <= 4'b1110;
            number <= '0;
            key_code <= '0;
            {start, add, sub, mult, div, enter, clr} <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            r <= r_n;
            c <= c_n;
            row_n <= ~(4'b0001 << r_n);
            busy <= state_n != S_SCAN;
            if (state == S_EMIT) begin
                key_code <= {r, c};
                if (is_digit) number <= 10'b1 << digit;
            end
            // strobes land one cycle after number/key_code so the digit has setup time
            start <= fire && is_digit;
            add <= fire && c == 2'd3 && r == 2'd0;
            sub <= fire && c == 2'd3 && r == 2'd1;
            mult <= fire && c == 2'd3 && r == 2'd2;
            div <= fire && c == 2'd3 && r == 2'd3;
            enter <= fire && r == 2'd3 && c == 2'd2;
            clr <= fire && r == 2'd3 && c == 2'd0;
        end
    end
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: directed checks of scanning, debounce, strobe timing,
// same-row priority, bounce rejection and reset during a pending strobe.
module tb_keypad_encoder;
    logic clk, reset;
    logic [3:0] row_n, col_n, key_code;
    logic [9:0] number;
    logic start, add, sub, mult, div, enter, clr, busy;
    logic [15:0] keys;
    int sc[7], base[7];
    int total = 0, passed = 0;

    keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE(4)) dut (
        .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n), .number(number),
        .start(start), .add(add), .sub(sub), .mult(mult), .div(div),
        .enter(enter), .clr(clr), .key_code(key_code), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // key matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_n = 4'hf;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (keys[i*4+j] && !row_n[i]) col_n[j] = 1'b0;
    end

    always @(negedge clk) begin
        if (start) sc[0]++;
        if (add) sc[1]++;
        if (sub) sc[2]++;
        if (mult) sc[3]++;
        if (div) sc[4]++;
        if (enter) sc[5]++;
        if (clr) sc[6]++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic snap();
        for (int i = 0; i < 7; i++) base[i] = sc[i];
    endtask

    task automatic check_strobes(input string tag, input int which);
        for (int i = 0; i < 7; i++) check(tag, sc[i] - base[i], i == which ? 1 : 0);
    endtask

    task automatic wait_busy(input string tag, input logic val);
        for (int i = 0; i < 64 && busy !== val; i++) @(negedge clk);
        check(tag, busy, val);
    endtask

    task automatic press(input logic [15:0] mask, input int hold);
        keys = mask;
        wait_busy("press_seen", 1'b1);
        repeat (hold) @(negedge clk);
        keys = '0;
        wait_busy("release_done", 1'b0);
    endtask

    initial begin
        logic [3:0] exp_row;
        for (int i = 0; i < 7; i++) sc[i] = 0;
        reset = 1'b1;
        keys = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        snap();
        check("rst_busy", busy, 0);
        check("rst_number", number, 0);
        check("rst_key_code", key_code, 0);
        for (int i = 0; i < 20; i++) begin
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            check("row_scan", row_n, exp_row);
            @(negedge clk);
        end
        check_strobes("idle_strobes", -1);
        check("idle_number", number, 0);

        snap();
        keys = 16'h0100;
        wait_busy("seven_press", 1'b1);
        repeat (4) @(negedge clk);
        check("seven_num_early", number, 0);
        check("seven_start_early", start, 0);
        @(negedge clk);
        check("seven_number", number, 10'b0010000000);
        check("seven_key_code", key_code, 8);
        check("seven_start_t6", start, 0);
        @(negedge clk);
        check("seven_start_t7", start, 1);
        @(negedge clk);
        check("seven_start_t8", start, 0);
        repeat (10) @(negedge clk);
        keys = '0;
        repeat (4) @(negedge clk);
        check("seven_rel_busy", busy, 1);
        @(negedge clk);
        check("seven_idle", busy, 0);
        check("seven_resume_row", row_n, 4'b0111);
        check_strobes("seven_strobes", 0);

        snap();
        press(16'h0008, 6);
        check_strobes("plus_strobes", 1);
        check("plus_number", number, 10'b0010000000);
        check("plus_key_code", key_code, 3);

        snap();
        keys = 16'h0020;
        wait_busy("bounce_press", 1'b1);
        repeat (2) @(negedge clk);
        keys = '0;
        @(negedge clk);
        check("bounce_busy_drop", busy, 0);
        repeat (20) @(negedge clk);
        check_strobes("bounce_strobes", -1);
        check("bounce_number", number, 10'b0010000000);
        check("bounce_key_code", key_code, 3);
        check("bounce_busy", busy, 0);

        snap();
        press(16'h0005, 6);
        check_strobes("pair_strobes", 0);
        check("pair_number", number, 10'b0000000010);
        check("pair_key_code", key_code, 0);

        snap();
        keys = 16'h4000;
        wait_busy("eq_press", 1'b1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_enter", enter, 0);
        check("rst2_number", number, 0);
        check("rst2_key_code", key_code, 0);
        check("rst2_row_n", row_n, 4'b1110);
        check("rst2_busy", busy, 0);
        check("rst2_no_enter", sc[5] - base[5], 0);
        wait_busy("eq_redetect", 1'b1);
        repeat (8) @(negedge clk);
        keys = '0;
        wait_busy("eq_release", 1'b0);
        check_strobes("eq_strobes", 5);
        check("eq_key_code", key_code, 14);
        check("eq_number", number, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
